// File: rtl/lcd_display_pkg.sv
// lcd_display_pkg
// Shared constants and the scanner FSM encoding for the LCD display-slot
// requester. The shadow entry holds {valid, name, value}.
package lcd_display_pkg;

  localparam int NUM_AREAS_MAX = 44;
  localparam int NAME_W        = 40;
  localparam int VALUE_W       = 32;
  localparam int NUM_W         = 6;
  localparam int ENTRY_W       = 1 + NAME_W + VALUE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_CMP,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/lcd_shadow_ram.sv
// lcd_shadow_ram
// Shadow copy of what the renderer currently shows for each area.
// Name/value live in a plain array with a registered read; the valid bits
// live in flops so that a reset wipes every area in a single cycle.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   rd_en_i, rd_addr_i       read request (area number 1..NUM_AREAS)
//   rd_valid_o/name_o/value_o registered read data, valid the cycle after rd_en_i
//   wr_en_i, wr_addr_i       write request (area number 1..NUM_AREAS)
//   wr_valid_i/name_i/value_i write data
module lcd_shadow_ram
  import lcd_display_pkg::*;
#(
  parameter int NUM_AREAS = NUM_AREAS_MAX
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rd_en_i,
  input  logic [NUM_W-1:0]   rd_addr_i,
  output logic               rd_valid_o,
  output logic [NAME_W-1:0]  rd_name_o,
  output logic [VALUE_W-1:0] rd_value_o,
  input  logic               wr_en_i,
  input  logic [NUM_W-1:0]   wr_addr_i,
  input  logic               wr_valid_i,
  input  logic [NAME_W-1:0]  wr_name_i,
  input  logic [VALUE_W-1:0] wr_value_i
);

  logic [ENTRY_W-2:0]   mem_q [NUM_AREAS];
  logic [NUM_AREAS-1:0] valid_q;
  logic [ENTRY_W-2:0]   rd_data_q;
  logic                 rd_valid_q;
  logic [NUM_W-1:0]     rd_slot;
  logic [NUM_W-1:0]     wr_slot;

  // Areas are numbered from 1, storage from 0.
  assign rd_slot = rd_addr_i - NUM_W'(1);
  assign wr_slot = wr_addr_i - NUM_W'(1);

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_slot] <= {wr_name_i, wr_value_i};
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_slot];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        valid_q[wr_slot] <= wr_valid_i;
      end
      if (rd_en_i) begin
        rd_valid_q <= valid_q[rd_slot];
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_name_o  = rd_data_q[ENTRY_W-2:VALUE_W];
  assign rd_value_o = rd_data_q[VALUE_W-1:0];

endmodule

// File: rtl/lcd_display_scanner.sv
// lcd_display_scanner
// Sweeps the user display logic over areas 1..NUM_AREAS, compares each
// registered reply with the shadow copy and emits only the changed areas to
// the LCD renderer over a valid/ready handshake.
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   display_number                 area being requested (0 while idle)
//   display_valid/name/value       registered reply from the user logic
//   refresh_all                    request to re-emit every valid area next sweep
//   upd_valid, upd_ready           update handshake to the renderer
//   upd_index/blank/name/value     update payload
//   frame_done                     one-cycle pulse at the end of a sweep
module lcd_display_scanner
  import lcd_display_pkg::*;
#(
  parameter int NUM_AREAS   = NUM_AREAS_MAX,
  parameter int REFRESH_DIV = 1000
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [NUM_W-1:0]   display_number,
  input  logic               display_valid,
  input  logic [NAME_W-1:0]  display_name,
  input  logic [VALUE_W-1:0] display_value,
  input  logic               refresh_all,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [NUM_W-1:0]   upd_index,
  output logic               upd_blank,
  output logic [NAME_W-1:0]  upd_name,
  output logic [VALUE_W-1:0] upd_value,
  output logic               frame_done
);

  localparam logic [NUM_W-1:0] LAST_IDX = NUM_W'(NUM_AREAS);
  localparam logic [31:0]      CNT_LAST = 32'(REFRESH_DIV - 1);

  state_e               state_q, state_d;
  logic [NUM_W-1:0]     idx_q, idx_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [NUM_AREAS-1:0] stale_q, stale_d;
  logic                 pend_q, pend_d;
  logic                 cap_valid_q;
  logic [NAME_W-1:0]    cap_name_q;
  logic [VALUE_W-1:0]   cap_value_q;

  logic                 sh_valid;
  logic [NAME_W-1:0]    sh_name;
  logic [VALUE_W-1:0]   sh_value;
  logic [NUM_W-1:0]     idx_slot;
  logic                 need_upd;
  logic                 handshake;
  logic                 leave_area;
  logic                 idle_expire;

  lcd_shadow_ram #(.NUM_AREAS(NUM_AREAS)) u_shadow (
    .clk        (clk),
    .resetn     (resetn),
    .rd_en_i    (state_q == ST_DRIVE),
    .rd_addr_i  (idx_q),
    .rd_valid_o (sh_valid),
    .rd_name_o  (sh_name),
    .rd_value_o (sh_value),
    .wr_en_i    (handshake),
    .wr_addr_i  (idx_q),
    .wr_valid_i (cap_valid_q),
    .wr_name_i  (cap_name_q),
    .wr_value_i (cap_value_q)
  );

  assign idx_slot    = idx_q - NUM_W'(1);
  assign idle_expire = (state_q == ST_IDLE) && (cnt_q == CNT_LAST);
  assign handshake   = (state_q == ST_EMIT) && upd_ready;

  // A valid reply emits when forced stale or when it differs from the shadow;
  // an invalid reply only emits (as a blank) if the area is currently shown.
  assign need_upd = cap_valid_q ? (stale_q[idx_slot] || !sh_valid ||
                                   (sh_name != cap_name_q) ||
                                   (sh_value != cap_value_q))
                                : sh_valid;

  assign leave_area = ((state_q == ST_CMP) && !need_upd) || handshake;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (idle_expire) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_CMP;
      ST_CMP: begin
        if (need_upd) begin
          state_d = ST_EMIT;
        end else begin
          state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_DRIVE;
        end
      end
      ST_EMIT: begin
        if (upd_ready) begin
          state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_DRIVE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: idle counter, area index, stale vector and the
  // pending refresh, which is only folded into stale when a sweep starts.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stale_d = stale_q;
    pend_d  = pend_q | refresh_all;
    if (state_q == ST_IDLE) begin
      if (idle_expire) begin
        cnt_d   = '0;
        idx_d   = NUM_W'(1);
        stale_d = stale_q | {NUM_AREAS{pend_d}};
        pend_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    if (leave_area) begin
      stale_d[idx_slot] = 1'b0;
      idx_d = (idx_q == LAST_IDX) ? NUM_W'(1) : idx_q + NUM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q       <= '0;
      idx_q       <= NUM_W'(1);
      stale_q     <= '1;
      pend_q      <= 1'b0;
      cap_valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stale_q <= stale_d;
      pend_q  <= pend_d;
      if (state_q == ST_SAMPLE) begin
        cap_valid_q <= display_valid;
      end
    end
  end

  // The reply is taken once per area, at the end of SAMPLE.
  always_ff @(posedge clk) begin
    if (state_q == ST_SAMPLE) begin
      cap_name_q  <= display_name;
      cap_value_q <= display_value;
    end
  end

  // Outputs: payload is forced to zero outside EMIT so reset leaves all
  // outputs low.
  always_comb begin
    display_number = '0;
    upd_valid      = 1'b0;
    upd_index      = '0;
    upd_blank      = 1'b0;
    upd_name       = '0;
    upd_value      = '0;
    frame_done     = leave_area && (idx_q == LAST_IDX);
    if (state_q != ST_IDLE) begin
      display_number = idx_q;
    end
    if (state_q == ST_EMIT) begin
      upd_valid = 1'b1;
      upd_index = idx_q;
      upd_blank = !cap_valid_q;
      upd_name  = cap_name_q;
      upd_value = cap_value_q;
    end
  end

endmodule

// File: tb/tb_lcd_display_scanner.sv
// Self-checking bench for lcd_display_scanner. A small user-logic model
// answers display requests; a per-area reference shadow predicts which
// updates each sweep must emit.
module tb_lcd_display_scanner;

  localparam int NA    = 44;
  localparam int RD    = 20;
  localparam int LIMIT = 5000;

  typedef struct packed {
    logic [5:0]  idx;
    logic        blank;
    logic [39:0] name;
    logic [31:0] value;
  } upd_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        refresh_all;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_index;
  logic        upd_blank;
  logic [39:0] upd_name;
  logic [31:0] upd_value;
  logic        frame_done;

  lcd_display_scanner #(.NUM_AREAS(NA), .REFRESH_DIV(RD)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .display_number (display_number),
    .display_valid  (display_valid),
    .display_name   (display_name),
    .display_value  (display_value),
    .refresh_all    (refresh_all),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_index      (upd_index),
    .upd_blank      (upd_blank),
    .upd_name       (upd_name),
    .upd_value      (upd_value),
    .frame_done     (frame_done)
  );

  always #50 clk = ~clk;

  // User-side contents and reference shadow
  logic        u_valid [1:NA];
  logic [39:0] u_name  [1:NA];
  logic [31:0] u_value [1:NA];
  logic        r_valid [1:NA];
  logic [39:0] r_name  [1:NA];
  logic [31:0] r_value [1:NA];
  logic        r_stale [1:NA];
  logic        r_pend;

  upd_t got_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ready_mode = 0;
  int frame_start = 0;
  int frame_len = 0;
  int last_nupd = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_number"}, 64'(display_number), 64'd0);
    checkOutput({tag, "_valid"},  64'(upd_valid),      64'd0);
    checkOutput({tag, "_blank"},  64'(upd_blank),      64'd0);
    checkOutput({tag, "_index"},  64'(upd_index),      64'd0);
    checkOutput({tag, "_name"},   64'(upd_name),       64'd0);
    checkOutput({tag, "_value"},  64'(upd_value),      64'd0);
    checkOutput({tag, "_done"},   64'(frame_done),     64'd0);
  endtask

  task automatic modelReset();
    for (int a = 1; a <= NA; a++) begin
      r_valid[a] = 1'b0;
      r_stale[a] = 1'b1;
    end
    r_pend = 1'b0;
  endtask

  // User logic: registers its reply one cycle after seeing the number.
  initial begin
    logic [5:0] n;
    display_valid = 1'b0;
    display_name  = '0;
    display_value = '0;
    forever begin
      @(negedge clk);
      n = display_number;
      @(posedge clk);
      #1;
      if (n >= 6'd1 && int'(n) <= NA) begin
        display_valid = u_valid[n];
        display_name  = u_name[n];
        display_value = u_value[n];
      end else begin
        display_valid = 1'b0;
        display_name  = '0;
        display_value = '0;
      end
    end
  end

  // Renderer ready: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    upd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       upd_ready = 1'b1;
        1:       upd_ready = 1'($urandom_range(0, 1));
        default: upd_ready = 1'b0;
      endcase
    end
  end

  // Monitor: collects handshakes, frame pulses and checks that a stalled
  // update stays put.
  initial begin
    logic       prev_stall;
    upd_t       prev_pl;
    prev_stall = 1'b0;
    prev_pl    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn) begin
        if (prev_stall) begin
          checkOutput("hold_valid", 64'(upd_valid), 64'd1);
          checkOutput("hold_idx_val", 64'({upd_index, upd_blank, upd_value}),
                      64'({prev_pl.idx, prev_pl.blank, prev_pl.value}));
          checkOutput("hold_name", 64'(upd_name), 64'(prev_pl.name));
        end
        if (upd_valid && upd_ready) begin
          got_q.push_back('{upd_index, upd_blank, upd_name, upd_value});
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = upd_valid && !upd_ready;
        prev_pl    = '{upd_index, upd_blank, upd_name, upd_value};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Runs one sweep and compares emitted updates with the reference shadow.
  // mode 1 pulses refresh_all mid-sweep, mode 2 stalls the first update.
  task automatic runFrame(input string tag, input int mode);
    upd_t expq[$];
    int   base;
    int   guard;
    bit   done_action;
    logic [5:0]  dn;
    upd_t        hold;
    base = done_cnt;
    guard = 0;
    done_action = 1'b0;
    if (r_pend) begin
      for (int a = 1; a <= NA; a++) r_stale[a] = 1'b1;
      r_pend = 1'b0;
    end
    got_q.delete();
    while (done_cnt == base && guard < LIMIT) begin
      @(negedge clk);
      guard++;
      if (mode == 1 && !done_action && display_number == 6'd20) begin
        @(posedge clk); #1 refresh_all = 1'b1;
        @(posedge clk); #1 refresh_all = 1'b0;
        r_pend = 1'b1;
        done_action = 1'b1;
      end
      if (mode == 2 && !done_action && upd_valid) begin
        dn   = display_number;
        hold = '{upd_index, upd_blank, upd_name, upd_value};
        repeat (10) begin
          @(negedge clk);
          checkOutput({tag, "_stall_valid"}, 64'(upd_valid), 64'd1);
          checkOutput({tag, "_stall_number"}, 64'(display_number), 64'(dn));
          checkOutput({tag, "_stall_value"}, 64'(upd_value), 64'(hold.value));
          checkOutput({tag, "_stall_name"}, 64'(upd_name), 64'(hold.name));
        end
        checkOutput({tag, "_stall_no_write"}, 64'(got_q.size()), 64'd0);
        ready_mode = 0;
        done_action = 1'b1;
      end
    end
    checkOutput({tag, "_frame_seen"}, 64'(guard < LIMIT), 64'd1);
    for (int a = 1; a <= NA; a++) begin
      bit need;
      need = u_valid[a] ? (r_stale[a] || !r_valid[a] || r_name[a] != u_name[a] ||
                           r_value[a] != u_value[a])
                        : r_valid[a];
      if (need) begin
        expq.push_back('{6'(a), !u_valid[a], u_name[a], u_value[a]});
        r_valid[a] = u_valid[a];
        r_name[a]  = u_name[a];
        r_value[a] = u_value[a];
      end
      r_stale[a] = 1'b0;
    end
    checkOutput({tag, "_count"}, 64'(got_q.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got_q.size(); i++) begin
      checkOutput({tag, "_idx"}, 64'(got_q[i].idx), 64'(expq[i].idx));
      checkOutput({tag, "_blank"}, 64'(got_q[i].blank), 64'(expq[i].blank));
      if (!expq[i].blank) begin
        checkOutput({tag, "_name"}, 64'(got_q[i].name), 64'(expq[i].name));
        checkOutput({tag, "_value"}, 64'(got_q[i].value), 64'(expq[i].value));
      end
    end
    last_nupd   = got_q.size();
    frame_len   = done_cyc - frame_start;
    frame_start = done_cyc;
    $display("[TB] %s: %0d updates, %0d cycles", tag, last_nupd, frame_len);
  endtask

  initial begin
    #(100 * 40000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int guard;
    int nvalid;
    resetn      = 1'b0;
    refresh_all = 1'b0;
    for (int a = 1; a <= NA; a++) begin
      u_valid[a] = 1'b0;
      u_name[a]  = '0;
      u_value[a] = '0;
      r_name[a]  = '0;
      r_value[a] = '0;
    end
    modelReset();
    u_valid[1] = 1'b1; u_name[1] = "Oper1"; u_value[1] = 32'h5;
    u_valid[2] = 1'b1; u_name[2] = "Oper2"; u_value[2] = 32'h3;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1 resetn = 1'b1;
    frame_start = cyc;

    runFrame("first", 0);
    checkOutput("first_nupd", 64'(last_nupd), 64'd2);
    checkOutput("first_len", 64'(frame_len), 64'(RD + 3 * NA + 2));

    runFrame("quiet", 0);
    checkOutput("quiet_nupd", 64'(last_nupd), 64'd0);
    checkOutput("quiet_len", 64'(frame_len), 64'(RD + 3 * NA));

    u_value[2] = 32'h7;
    runFrame("change2", 0);
    checkOutput("change2_nupd", 64'(last_nupd), 64'd1);
    checkOutput("change2_len", 64'(frame_len), 64'(RD + 3 * NA + 1));

    u_valid[1] = 1'b0;
    runFrame("blank1", 0);
    checkOutput("blank1_nupd", 64'(last_nupd), 64'd1);
    runFrame("after_blank", 0);
    checkOutput("after_blank_nupd", 64'(last_nupd), 64'd0);

    u_valid[3] = 1'b1; u_name[3] = "Oper3"; u_value[3] = 32'h9;
    ready_mode = 2;
    runFrame("stall", 2);
    checkOutput("stall_nupd", 64'(last_nupd), 64'd1);
    runFrame("after_stall", 0);
    checkOutput("after_stall_nupd", 64'(last_nupd), 64'd0);

    runFrame("refresh_mid", 1);
    checkOutput("refresh_mid_nupd", 64'(last_nupd), 64'd0);
    runFrame("refresh_next", 0);
    checkOutput("refresh_next_nupd", 64'(last_nupd), 64'd2);

    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        int a;
        a = int'($urandom_range(1, NA));
        u_valid[a] = 1'($urandom_range(0, 1));
        u_name[a]  = 40'({$urandom(), $urandom()});
        u_value[a] = $urandom();
      end
      runFrame($sformatf("rand%0d", f), 0);
    end
    ready_mode = 0;
    runFrame("rand_settle", 0);

    // Reset while an update is waiting for the renderer
    u_valid[2] = 1'b1;
    u_value[2] = r_value[2] + 32'd1;
    ready_mode = 2;
    guard = 0;
    while (!upd_valid && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("emit_reached", 64'(guard < LIMIT), 64'd1);
    @(posedge clk); #1 resetn = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1 resetn = 1'b1;
    frame_start = cyc;
    modelReset();
    @(negedge clk);
    checkResetOutputs("mid_emit_reset");
    nvalid = 0;
    for (int a = 1; a <= NA; a++) if (u_valid[a]) nvalid++;
    runFrame("post_reset", 0);
    checkOutput("post_reset_nupd", 64'(last_nupd), 64'(nvalid));
    checkOutput("post_reset_len", 64'(frame_len), 64'(RD + 3 * NA + nvalid));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
